reg_file_rv32i: RTL and testbench
=================================

Name: reg_file_rv32i

Overview:
- RV32I integer register file: the operand source and result sink on either side of the ALU datapath.
- Drives the ALU operand inputs (in1 = rs1 data, in2 = rs2 data) and accepts the ALU result on its write port.
- Two read ports and one write port, with x0 hardwired to zero.
- Optional registered-read mode for the pipelined datapath variant. Configurable stack-pointer reset value.

Parameters:
- XLEN, 32, data width of each register.
- SP_RESET, 32'h0000_0000, value loaded into x2 (sp) on reset. All other registers reset to 0.
- REG_READ, 0, read mode. 0 = combinational read, 0-cycle latency. 1 = registered read outputs, 1-cycle latency.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs1_addr  in  5  read port 1 register index.
- rs2_addr  in  5  read port 2 register index.
- rd_addr  in  5  write port register index.
- rd_data  in  XLEN  write data (ALU result or writeback mux output).
- rd_we  in  1  write enable.
- rd_valid  in  1  qualifies rd_we; a write occurs only when rd_we & rd_valid.
- rs1_data  out  XLEN  read data port 1 (feeds ALU in1).
- rs2_data  out  XLEN  read data port 2 (feeds ALU in2).
- dbg_addr  in  5  debug/bench read index.
- dbg_data  out  XLEN  debug read data; always combinational, never bypassed.

Behaviour:
- Reset:
  - rst_n low asynchronously sets x1..x31 to 0, except x2 = SP_RESET.
  - When REG_READ=1, the rs1_data/rs2_data output registers clear to 0.
  - While rst_n is low, writes are ignored.
  - Deassertion is not synchronised inside the block; it is synchronised externally.
- Storage:
  - 31 physical registers, x1..x31. No storage for x0.
  - Reading index 0 returns 0 on every port, including dbg_data.
- Write:
  - Occurs on the rising clk edge when rst_n=1, rd_we=1, rd_valid=1 and rd_addr!=0.
  - A write to x0 is silently dropped: no state change and no bypass.
- REG_READ=0 (combinational read):
  - rsN_data = reg[rsN_addr] in the same cycle.
  - Write-first bypass: if a qualified write in the current cycle targets rsN_addr (non-zero), rsN_data = rd_data. This gives the same-cycle writeback-to-decode forward.
- REG_READ=1 (registered read):
  - At each clk edge, the rsN_data registers capture the bypassed value of rsN_addr, using the same bypass rule.
  - A read issued in the same cycle as a write to that index returns the new data in the next cycle.
- Both ports may read the same index simultaneously, and both may match the write index; both are bypassed.
- dbg_data = reg[dbg_addr] with no bypass. It shows pre-write contents in the write cycle and the new value after the edge.
- Reset asserted mid-operation: an in-flight write in that cycle is lost, and the registers hold reset values until release.
- Width rule: data is stored verbatim; no sign or zero manipulation.

Decomposition:
- Shared package rv32i_pkg:
  - XLEN and the register-index width (5).
  - Named constants for the ABI indices: REG_ZERO=0, REG_RA=1, REG_SP=2, REG_GP=3.
  - The ALU type encodings (XOR=2'b00, OR=2'b01, AND=2'b10), so the decode/control logic and the datapath agree.
- One sub-module is natural: reg_file_read_port. It does the index compare, x0 forcing, bypass select and optional output register, and is instantiated twice. Storage and write logic stay in the top module.

Test Plan:
- Reset check:
  - Stimulus: assert rst_n=0 mid-run with SP_RESET=32'h0001_0000, then read x1..x31 via dbg.
  - Required: x2=32'h0001_0000, all others 0, and outputs 0 in REG_READ=1 mode.
- x0 immutability:
  - Stimulus: write rd_addr=0, rd_data=32'hDEAD_BEEF, rd_we=1, rd_valid=1, while rs1_addr=0 in the same cycle.
  - Required: rs1_data=0 in the same cycle and every later cycle.
- Basic write/read:
  - Stimulus: write x5=32'h1234_5678, then set rs1_addr=5 and rs2_addr=5 next cycle.
  - Required: both ports give 32'h1234_5678. With REG_READ=1 they appear one cycle after the address is applied.
- Bypass:
  - Stimulus: x7 holds 32'hAAAA_AAAA; in one cycle write x7=32'h5555_5555 with rs2_addr=7.
  - Required: REG_READ=0 gives rs2_data=32'h5555_5555 combinationally while dbg_data=32'hAAAA_AAAA. REG_READ=1 gives 32'h5555_5555 the next cycle.
- Qualifier:
  - Stimulus: rd_we=1, rd_valid=0, rd_addr=9, rd_data=32'hFFFF_FFFF.
  - Required: x9 is unchanged and no bypass occurs. Repeat with rd_we=0, rd_valid=1: same result.
- ALU loop:
  - Stimulus: x1=32'hF0F0_F0F0, x2=32'h0FF0_0FF0; feed rs1/rs2 into an ALU with type=2'b00 and write the result to x3.
  - Required: x3=32'hFF00_FF00. Repeat with type=2'b01 giving 32'hFFF0_FFF0 and type=2'b10 giving 32'h00F0_00F0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: data width, register-index width, ABI register
// indices and the ALU operation encodings used by decode and datapath alike.
package rv32i_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd1;
   localparam logic [REG_IDX_W-1:0] REG_SP   = 5'd2;
   localparam logic [REG_IDX_W-1:0] REG_GP   = 5'd3;

   typedef enum logic [1:0] {
      ALU_XOR = 2'b00,
      ALU_OR  = 2'b01,
      ALU_AND = 2'b10
   } alu_type_e;

   function automatic logic [XLEN-1:0] alu_apply(input alu_type_e op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      logic [XLEN-1:0] res;
      case (op)
         ALU_XOR: res = a ^ b;
         ALU_OR:  res = a | b;
         ALU_AND: res = a & b;
         default: res = {XLEN{1'b0}};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One register-file read port: x0 forcing, write-first bypass and an optional
// output register selected by REG_READ.
module reg_file_read_port
   import rv32i_pkg::*;
#(
   parameter int XLEN     = rv32i_pkg::XLEN,
   parameter int REG_READ = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REG_IDX_W-1:0] rs_addr,
   input  logic [XLEN-1:0]      reg_data,
   input  logic                 wr_en,
   input  logic [REG_IDX_W-1:0] wr_addr,
   input  logic [XLEN-1:0]      wr_data,
   output logic [XLEN-1:0]      rs_data
);

   logic [XLEN-1:0] sel_s;
   logic [XLEN-1:0] data_r;

   // Select x0 zero, bypassed write data, or stored contents.
   always_comb begin
      sel_s = reg_data;
      if (rs_addr == REG_ZERO) begin
         sel_s = {XLEN{1'b0}};
      end else if (wr_en && (wr_addr == rs_addr)) begin
         sel_s = wr_data;
      end else begin
         sel_s = reg_data;
      end
   end

   // Output register; only observed when REG_READ is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= {XLEN{1'b0}};
      end else begin
         data_r <= sel_s;
      end
   end

   assign rs_data = (REG_READ != 0) ? data_r : sel_s;

endmodule

// File: rtl/reg_file_rv32i.sv
// RV32I integer register file: 31 stored registers (x0 hardwired to zero),
// two bypassed read ports, one qualified write port and a raw debug read.
module reg_file_rv32i
   import rv32i_pkg::*;
#(
   parameter int              XLEN     = rv32i_pkg::XLEN,
   parameter logic [XLEN-1:0] SP_RESET = 32'h0000_0000,
   parameter int              REG_READ = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REG_IDX_W-1:0] rs1_addr,
   input  logic [REG_IDX_W-1:0] rs2_addr,
   input  logic [REG_IDX_W-1:0] rd_addr,
   input  logic [XLEN-1:0]      rd_data,
   input  logic                 rd_we,
   input  logic                 rd_valid,
   output logic [XLEN-1:0]      rs1_data,
   output logic [XLEN-1:0]      rs2_data,
   input  logic [REG_IDX_W-1:0] dbg_addr,
   output logic [XLEN-1:0]      dbg_data
);

   logic [XLEN-1:0] regs_r [1:31];
   logic [XLEN-1:0] rd_vec_s [0:31];
   logic            we_s;

   assign we_s = rd_we & rd_valid & (rd_addr != REG_ZERO);

   // Storage update: reset values, then qualified writes to x1..x31.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++) begin
            regs_r[i] <= (REG_IDX_W'(i) == REG_SP) ? SP_RESET : {XLEN{1'b0}};
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (we_s && (rd_addr == REG_IDX_W'(i))) begin
               regs_r[i] <= rd_data;
            end
         end
      end
   end

   // Full 32-entry view so every 5-bit index lands in range; entry 0 is zero.
   always_comb begin
      rd_vec_s[0] = {XLEN{1'b0}};
      for (int i = 1; i < 32; i++) begin
         rd_vec_s[i] = regs_r[i];
      end
   end

   assign dbg_data = rd_vec_s[dbg_addr];

   reg_file_read_port #(
      .XLEN     (XLEN),
      .REG_READ (REG_READ)
   ) u_port1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs_addr  (rs1_addr),
      .reg_data (rd_vec_s[rs1_addr]),
      .wr_en    (we_s),
      .wr_addr  (rd_addr),
      .wr_data  (rd_data),
      .rs_data  (rs1_data)
   );

   reg_file_read_port #(
      .XLEN     (XLEN),
      .REG_READ (REG_READ)
   ) u_port2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs_addr  (rs2_addr),
      .reg_data (rd_vec_s[rs2_addr]),
      .wr_en    (we_s),
      .wr_addr  (rd_addr),
      .wr_data  (rd_data),
      .rs_data  (rs2_data)
   );

endmodule

// File: tb/tb_reg_file_rv32i.sv
// Directed bench driving a combinational-read and a registered-read instance
// with shared stimulus and hand-computed expectations.
module tb_reg_file_rv32i;
   import rv32i_pkg::*;

   localparam logic [31:0] SP_VAL = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
   logic [31:0] rd_data;
   logic        rd_we, rd_valid;
   logic [31:0] c_rs1, c_rs2, c_dbg;
   logic [31:0] r_rs1, r_rs2, r_dbg;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_v;

   always #5 clk = ~clk;

   reg_file_rv32i #(.XLEN(32), .SP_RESET(SP_VAL), .REG_READ(0)) u_comb (
      .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we), .rd_valid(rd_valid),
      .rs1_data(c_rs1), .rs2_data(c_rs2), .dbg_addr(dbg_addr), .dbg_data(c_dbg)
   );

   reg_file_rv32i #(.XLEN(32), .SP_RESET(SP_VAL), .REG_READ(1)) u_reg (
      .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we), .rd_valid(rd_valid),
      .rs1_data(r_rs1), .rs2_data(r_rs2), .dbg_addr(dbg_addr), .dbg_data(r_dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      rd_addr = a; rd_data = d; rd_we = 1'b1; rd_valid = 1'b1;
      tick();
      rd_we = 1'b0; rd_valid = 1'b0;
   endtask

   task automatic check_dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
      dbg_addr = a;
      #1;
      check({tag, "_comb"}, c_dbg, exp);
      check({tag, "_reg"}, r_dbg, exp);
   endtask

   initial begin
      rst_n = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
      dbg_addr = 5'd0; rd_data = 32'h0; rd_we = 1'b0; rd_valid = 1'b0;
      tick(); tick();
      check("init_rs1_reg", r_rs1, 32'h0);
      rst_n = 1'b1;
      check_dbg("init_sp", 5'd2, SP_VAL);

      // Mid-run reset with an in-flight write
      write_reg(5'd1, 32'h1111_1111);
      write_reg(5'd4, 32'h4444_4444);
      rs1_addr = 5'd1; rs2_addr = 5'd4;
      tick();
      check("pre_rst_rs1_reg", r_rs1, 32'h1111_1111);
      check("pre_rst_rs2_reg", r_rs2, 32'h4444_4444);
      rd_addr = 5'd5; rd_data = 32'hDEAD_0005; rd_we = 1'b1; rd_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_rs1_reg", r_rs1, 32'h0);
      check("rst_rs2_reg", r_rs2, 32'h0);
      tick();
      for (int i = 1; i < 32; i++) begin
         exp_v = (i == 2) ? SP_VAL : 32'h0;
         check_dbg($sformatf("rst_x%0d", i), 5'(i), exp_v);
      end
      check("rst_hold_rs1_reg", r_rs1, 32'h0);
      rd_we = 1'b0; rd_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      check_dbg("rst_lost_x5", 5'd5, 32'h0);

      // x0 immutability
      rs1_addr = 5'd0; rs2_addr = 5'd0;
      rd_addr = 5'd0; rd_data = 32'hDEAD_BEEF; rd_we = 1'b1; rd_valid = 1'b1;
      #1;
      check("x0_same_comb", c_rs1, 32'h0);
      tick();
      check("x0_next_comb", c_rs1, 32'h0);
      check("x0_next_reg", r_rs1, 32'h0);
      rd_we = 1'b0; rd_valid = 1'b0;
      tick();
      check("x0_later_reg", r_rs1, 32'h0);
      check_dbg("x0_dbg", 5'd0, 32'h0);

      // Basic write then read
      write_reg(5'd5, 32'h1234_5678);
      rs1_addr = 5'd5; rs2_addr = 5'd5;
      #1;
      check("basic_rs1_comb", c_rs1, 32'h1234_5678);
      check("basic_rs2_comb", c_rs2, 32'h1234_5678);
      check("basic_lat_reg", r_rs1, 32'h0);
      tick();
      check("basic_rs1_reg", r_rs1, 32'h1234_5678);
      check("basic_rs2_reg", r_rs2, 32'h1234_5678);

      // Write-first bypass, both ports on the write index
      write_reg(5'd7, 32'hAAAA_AAAA);
      rd_addr = 5'd7; rd_data = 32'h5555_5555; rd_we = 1'b1; rd_valid = 1'b1;
      rs1_addr = 5'd7; rs2_addr = 5'd7; dbg_addr = 5'd7;
      #1;
      check("byp_rs2_comb", c_rs2, 32'h5555_5555);
      check("byp_rs1_comb", c_rs1, 32'h5555_5555);
      check("byp_dbg_comb", c_dbg, 32'hAAAA_AAAA);
      check("byp_dbg_reg", r_dbg, 32'hAAAA_AAAA);
      tick();
      rd_we = 1'b0; rd_valid = 1'b0;
      check("byp_rs2_reg", r_rs2, 32'h5555_5555);
      check("byp_rs1_reg", r_rs1, 32'h5555_5555);
      check_dbg("byp_after", 5'd7, 32'h5555_5555);

      // Write qualifier
      write_reg(5'd9, 32'h9999_0000);
      for (int k = 0; k < 2; k++) begin
         rd_addr = 5'd9; rd_data = 32'hFFFF_FFFF;
         rd_we = (k == 0); rd_valid = (k != 0);
         rs1_addr = 5'd9;
         #1;
         check($sformatf("qual%0d_rs1_comb", k), c_rs1, 32'h9999_0000);
         tick();
         check($sformatf("qual%0d_rs1_reg", k), r_rs1, 32'h9999_0000);
         check_dbg($sformatf("qual%0d_x9", k), 5'd9, 32'h9999_0000);
         rd_we = 1'b0; rd_valid = 1'b0;
      end

      // ALU loop: x3 = x1 op x2
      write_reg(5'd1, 32'hF0F0_F0F0);
      write_reg(5'd2, 32'h0FF0_0FF0);
      rs1_addr = 5'd1; rs2_addr = 5'd2;
      tick();
      check("alu_in1_reg", r_rs1, 32'hF0F0_F0F0);
      check("alu_in2_reg", r_rs2, 32'h0FF0_0FF0);
      for (int k = 0; k < 3; k++) begin
         alu_type_e op;
         op = alu_type_e'(k);
         exp_v = (k == 0) ? 32'hFF00_FF00 : (k == 1) ? 32'hFFF0_FFF0 : 32'h00F0_00F0;
         #1;
         write_reg(5'd3, alu_apply(op, c_rs1, c_rs2));
         check_dbg($sformatf("alu%0d_x3", k), 5'd3, exp_v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
